// File: rtl/scan_display_ctrl.sv
// Four-digit seven-segment scan controller with a round-robin write port shared by two requesters.
// Each digit is shown for SCAN_DIV cycles, then the display is blanked for one cycle before the next digit.
//
// state | meaning
// SHOW  | drive digit idx for SCAN_DIV cycles
// GAP   | one blank cycle, advance idx
module scan_display_ctrl #(
   parameter int SCAN_DIV = 4,
   parameter int DIV_W    = 16
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [1:0] req0_addr,
   input  logic [3:0] req0_data,
   input  logic       req0_dp,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [1:0] req1_addr,
   input  logic [3:0] req1_data,
   input  logic       req1_dp,
   output logic [7:0] Seg,
   output logic [3:0] Sel
);

   typedef enum logic {SHOW, GAP} state_t;

   localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(SCAN_DIV - 1);

   state_t           state, state_nx;
   logic [1:0]       idx, idx_nx;
   logic [DIV_W-1:0] pre, pre_nx;
   logic [3:0]       sel_nx;
   logic [7:0]       seg_nx;

   logic [3:0][3:0]  dig_data;
   logic [3:0]       dig_dp;
   logic [3:0]       dig_en;

   logic             rr_ptr;
   logic             hs0, hs1;
   logic [1:0]       wr_addr;
   logic [3:0]       wr_data;
   logic             wr_dp;

   function automatic logic [6:0] decode(input logic [3:0] hex);
      logic [6:0] s;
      case (hex)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Contention goes to the requester the fairness pointer names; a lone requester always wins.
   assign req0_ready = req0_valid & (~req1_valid | ~rr_ptr);
   assign req1_ready = req1_valid & (~req0_valid |  rr_ptr);
   assign hs0        = req0_valid & req0_ready;
   assign hs1        = req1_valid & req1_ready;
   assign wr_addr    = hs0 ? req0_addr : req1_addr;
   assign wr_data    = hs0 ? req0_data : req1_data;
   assign wr_dp      = hs0 ? req0_dp   : req1_dp;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         rr_ptr   <= 1'b0;
         dig_data <= '0;
         dig_dp   <= '0;
         dig_en   <= '0;
      end else if (hs0 || hs1) begin
         rr_ptr            <= hs0;
         dig_data[wr_addr] <= wr_data;
         dig_dp[wr_addr]   <= wr_dp;
         dig_en[wr_addr]   <= 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= SHOW;
         idx   <= 2'd0;
         pre   <= '0;
         Sel   <= 4'b0000;
         Seg   <= 8'h00;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         pre   <= pre_nx;
         Sel   <= sel_nx;
         Seg   <= seg_nx;
      end
   end

   // Pin values are computed from this cycle's state and digit regs and appear one edge later.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      pre_nx   = pre;
      sel_nx   = 4'b0000;
      seg_nx   = 8'h00;
      case (state)
         SHOW: begin
            sel_nx = 4'b0001 << idx;
            if (dig_en[idx]) begin
               seg_nx = {dig_dp[idx], decode(dig_data[idx])};
            end
            if (pre == PRE_LAST) begin
               pre_nx   = '0;
               state_nx = GAP;
            end else begin
               pre_nx = pre + DIV_W'(1);
            end
         end
         GAP: begin
            idx_nx   = idx + 2'd1;
            state_nx = SHOW;
         end
         default: state_nx = SHOW;
      endcase
   end

endmodule

// File: doc/scan_display_ctrl.md
Name: scan_display_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit seven-segment display (Seg/Sel resource).
- Holds four digit registers and arbitrates digit writes from two requesters using a round-robin valid/ready handshake.
- Sequences the digit scan with a prescaler and a one-cycle inter-digit blanking gap (ghost suppression).
- Drives Seg/Sel directly to the board pins.

Parameters:
- SCAN_DIV, 4, Clk cycles each digit is shown per scan slot (>=1); synthesis builds override with a larger value.
- DIV_W, 16, width of the prescaler counter; must hold SCAN_DIV-1.

Ports:
- Clk  in  1  system clock
- Rst  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 write request
- req0_ready  out  1  requester 0 grant (combinational)
- req0_addr  in  2  requester 0 target digit index 0..3
- req0_data  in  4  requester 0 hex value
- req0_dp  in  1  requester 0 decimal point
- req1_valid / req1_ready / req1_addr / req1_data / req1_dp  same widths and meanings for requester 1
- Seg  out  8  segment drive, active-high; [6:0]=g..a, [7]=dp
- Sel  out  4  digit select, one-hot active-high; Sel[i] selects digit i

Behaviour:
- Reset (Rst=0, asynchronous, also mid-operation):
  - Immediately: Sel=4'b0000, Seg=8'h00.
  - State=SHOW, idx=0, prescaler=0, rr_ptr=0.
  - All digit regs: data=0, dp=0, en=0.
- Scan FSM:
  - SHOW: Sel=one-hot(idx); Seg={dp,decode(data)} if en[idx]=1, else 8'h00. Prescaler increments each cycle; at prescaler==SCAN_DIV-1, next state=GAP and prescaler clears.
  - GAP: exactly 1 cycle; Sel=0, Seg=0. idx<=idx+1 (wraps 3->0); next state=SHOW.
  - Digit slot = SCAN_DIV+1 cycles; frame = 4*(SCAN_DIV+1) cycles.
  - First SHOW cycle after reset release shows digit 0.
- Seg/Sel are registered: values reflect FSM state and digit regs of the current cycle, i.e. one cycle after the causing edge.
- Hex decode (bits [6:0]): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Arbitration (combinational ready):
  - Only one valid: that requester gets ready=1.
  - Both valid: requester rr_ptr gets ready=1; the other gets 0.
  - Neither valid: both ready=0; at most one ready is ever high.
  - On handshake (valid&ready) by requester k: digit[addr]<={data,dp}, en[addr]<=1 at that edge; rr_ptr<=~k.
  - No handshake: rr_ptr holds.
- Write and scan are independent: a write is never stalled by the scan. If the written digit is currently in SHOW, Seg shows the new value from the cycle after the write edge.
- A write to the same digit on consecutive cycles is permitted; last write wins.
- The fairness pointer is the only arbitration state; no starvation with both requesters continuously valid.

Test Plan:
- Reset release with no writes, SCAN_DIV=4 -> Seg=00 throughout; Sel cycles 0001(4 cycles), 0000(1), 0010(4), 0000, 0100, 0000, 1000, 0000, repeating every 20 cycles.
- req0 writes addr=2, data=5, dp=1 -> next slot of digit 2: Sel=0100 with Seg=8'hED; other digits Seg=00.
- req0 and req1 both valid continuously, different addrs, after reset -> grants alternate 0,1,0,1; req0_ready and req1_ready never high together; both digits end enabled.
- Only req1 valid while rr_ptr=1 or 0 -> req1_ready=1 in the same cycle regardless of rr_ptr.
- Write addr=0, data=A while digit 0 is in SHOW -> Seg changes 00->77 one cycle after the write edge, Sel unchanged.
- Assert Rst low mid-frame after writes -> Seg=00 and Sel=0000 immediately (before next Clk edge). After release: scan restarts at digit 0 and all digits are blank.
